// File: rtl/entropy_encode_dc_multich.sv
// Streaming multi-channel DC entropy encoder: per-channel prediction, adaptive Exp-Golomb/Rice codes.
// Optional per-channel emitted-bit counters (out_bitcnt) are built when DC_BITCNT_EN is defined.
module entropy_encode_dc_multich #(
    parameter  int COEFF_W = 16,
    parameter  int NUM_CH  = 3,
    parameter  int CH_W    = 2,
    localparam int CW_W    = 2*COEFF_W+4,
    localparam int LEN_W   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [COEFF_W-1:0]  in_dc,
    input  logic [CH_W-1:0]     in_ch,
    input  logic                in_first,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW_W-1:0]     out_code,
    output logic [LEN_W-1:0]    out_len,
    output logic [CH_W-1:0]     out_ch,
    output logic                err_ch
`ifdef DC_BITCNT_EN
    ,
    output logic [32*NUM_CH-1:0] out_bitcnt
`endif
);

    localparam int D_W = COEFF_W + 1;  // prediction residual
    localparam int V_W = COEFF_W + 2;  // folded unsigned symbol
    localparam int N_W = COEFF_W + 3;  // symbol plus Exp-Golomb offset
    localparam int M_W = LEN_W - 1;    // bit index of the leading one

    typedef enum logic [2:0] {MODE_EG0, MODE_EG1, MODE_HYB, MODE_EG3, MODE_K5} mode_e;

    logic adv, accept, ch_ok;

    // The whole pipeline moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    logic [COEFF_W-1:0] prev_dc   [NUM_CH];
    logic [D_W-1:0]     prev_diff [NUM_CH];

    logic [COEFF_W-1:0] cur_prev_dc;
    logic [D_W-1:0]     cur_prev_diff, raw_diff, abs_diff, s1_d_nx;
    mode_e              s1_mode_nx;

    logic               s1_valid, s2_valid;
    logic [D_W-1:0]     s1_d;
    mode_e              s1_mode, s2_mode;
    logic [CH_W-1:0]    s1_ch, s2_ch;
    logic [V_W-1:0]     s2_v_nx, s2_v;

    // Stage 1: context lookup and residual/mode selection.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ch_ok         = 1'b0;
        cur_prev_dc   = '0;
        cur_prev_diff = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_ch == CH_W'(c)) begin
                ch_ok         = 1'b1;
                cur_prev_dc   = prev_dc[c];
                cur_prev_diff = prev_diff[c];
            end
        end
        raw_diff = {in_dc[COEFF_W-1], in_dc} - {cur_prev_dc[COEFF_W-1], cur_prev_dc};
        abs_diff = cur_prev_diff[D_W-1] ? -cur_prev_diff : cur_prev_diff;
        if (in_first) begin
            s1_d_nx    = {in_dc[COEFF_W-1], in_dc};
            s1_mode_nx = MODE_K5;
        end else begin
            s1_d_nx = cur_prev_diff[D_W-1] ? -raw_diff : raw_diff;
            if (abs_diff == D_W'(0))      s1_mode_nx = MODE_EG0;
            else if (abs_diff == D_W'(1)) s1_mode_nx = MODE_EG1;
            else if (abs_diff == D_W'(2)) s1_mode_nx = MODE_HYB;
            else                          s1_mode_nx = MODE_EG3;
        end
    end

    // Stage 2: fold signed residual onto unsigned symbol; -2d-1 equals ~(2d).
    assign s2_v_nx = s1_d[D_W-1] ? ~{s1_d, 1'b0} : {s1_d, 1'b0};

    function automatic logic [M_W-1:0] flog2(input logic [N_W-1:0] x);
        logic [M_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_W; i++)
            if (x[i]) r = M_W'(i);
        return r;
    endfunction

    logic [2:0]       k;
    logic [N_W-1:0]   n;
    logic [M_W-1:0]   msb;
    logic [CW_W-1:0]  code_nx;
    logic [LEN_W-1:0] len_nx;

    // Stage 3: codeword and length. EGk length collapses to 2*msb+1-k.
    always_comb begin
        k       = '0;
        n       = '0;
        msb     = '0;
        code_nx = '0;
        len_nx  = '0;
        if (s2_mode == MODE_HYB) begin
            if (s2_v < V_W'(8)) begin
                code_nx = CW_W'({1'b1, s2_v[1:0]});
                len_nx  = LEN_W'(3) + LEN_W'(s2_v[2]);
            end else begin
                // Three-zero escape followed by EG3 of v-8: the code value is v itself.
                msb     = flog2({1'b0, s2_v});
                code_nx = CW_W'(s2_v);
                len_nx  = {msb, 1'b1};
            end
        end else begin
            case (s2_mode)
                MODE_EG1: k = 3'd1;
                MODE_EG3: k = 3'd3;
                MODE_K5:  k = 3'd5;
                default:  k = 3'd0;
            endcase
            n       = {1'b0, s2_v} + (N_W'(1) << k);
            msb     = flog2(n);
            code_nx = CW_W'(n);
            len_nx  = {msb, 1'b1} - LEN_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the predictor contexts are architectural state (prev_diff restarts at 3), so they are reset like any register.
            for (int c = 0; c < NUM_CH; c++) begin
                prev_dc[c]   <= '0;
                prev_diff[c] <= D_W'(3);
            end
            err_ch    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_d      <= '0;
            s1_mode   <= MODE_EG0;
            s1_ch     <= '0;
            s2_valid  <= 1'b0;
            s2_v      <= '0;
            s2_mode   <= MODE_EG0;
            s2_ch     <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_len   <= '0;
            out_ch    <= '0;
        end else begin
            if (accept && !ch_ok)
                err_ch <= 1'b1;
            // Context updates at accept so a back-to-back word of the same channel sees it.
            if (accept) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (in_ch == CH_W'(c)) begin
                        prev_dc[c]   <= in_dc;
                        prev_diff[c] <= in_first ? D_W'(3) : raw_diff;
                    end
                end
            end
            if (adv) begin
                s1_valid  <= accept && ch_ok;
                s1_d      <= s1_d_nx;
                s1_mode   <= s1_mode_nx;
                s1_ch     <= in_ch;
                s2_valid  <= s1_valid;
                s2_v      <= s2_v_nx;
                s2_mode   <= s1_mode;
                s2_ch     <= s1_ch;
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_code <= code_nx;
                    out_len  <= len_nx;
                    out_ch   <= s2_ch;
                end
            end
        end
    end

`ifdef DC_BITCNT_EN
    logic        s1_first, s2_first, out_first;
    logic [31:0] bitcnt [NUM_CH];

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [LEN_W-1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? '1 : s[31:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_first  <= 1'b0;
            s2_first  <= 1'b0;
            out_first <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                bitcnt[c] <= '0;
        end else begin
            if (adv) begin
                s1_first  <= in_first;
                s2_first  <= s1_first;
                out_first <= s2_first;
            end
            if (out_valid && out_ready) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (out_ch == CH_W'(c))
                        bitcnt[c] <= out_first ? 32'(out_len) : sat_add(bitcnt[c], out_len);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_bitcnt
        assign out_bitcnt[32*g +: 32] = bitcnt[g];
    end
`endif

endmodule

// File: tb/tb_entropy_encode_dc_multich.sv
// Self-checking bench for entropy_encode_dc_multich: arithmetic reference model plus directed literal vectors.
// Covers out_bitcnt as well when DC_BITCNT_EN is defined.
module tb_entropy_encode_dc_multich;

    localparam int COEFF_W = 16;
    localparam int NUM_CH  = 3;
    localparam int CH_W    = 2;
    localparam int CW_W    = 2*COEFF_W+4;
    localparam int LEN_W   = 6;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [COEFF_W-1:0] in_dc = '0;
    logic [CH_W-1:0]    in_ch = '0;
    logic               in_first = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [CW_W-1:0]    out_code;
    logic [LEN_W-1:0]   out_len;
    logic [CH_W-1:0]    out_ch;
    logic               err_ch;
`ifdef DC_BITCNT_EN
    logic [32*NUM_CH-1:0] out_bitcnt;
`endif

    always #5 clk = ~clk;

    entropy_encode_dc_multich #(.COEFF_W(COEFF_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dc     (in_dc),
        .in_ch     (in_ch),
        .in_first  (in_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_len   (out_len),
        .out_ch    (out_ch),
        .err_ch    (err_ch)
`ifdef DC_BITCNT_EN
        ,
        .out_bitcnt(out_bitcnt)
`endif
    );

    typedef struct {
        int code;
        int len;
        int ch;
        bit first;
    } word_t;

    word_t  exp_q[$];
    word_t  got_q[$];
    word_t  ref_q[$];
    int     m_prev_dc   [NUM_CH];
    int     m_prev_diff [NUM_CH];
    longint m_bc        [NUM_CH];
    bit     m_err;
    int     n_vec = 0;
    int     n_err = 0;
    int     n_acc = 0;
    bit     held = 1'b0;
    logic [CW_W-1:0]  h_code;
    logic [LEN_W-1:0] h_len;
    logic [CH_W-1:0]  h_ch;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic int flog2(input int x);
        int m = 0;
        while ((x >> (m + 1)) != 0) m++;
        return m;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            m_prev_dc[c]   = 0;
            m_prev_diff[c] = 3;
            m_bc[c]        = 0;
        end
        m_err = 1'b0;
        held  = 1'b0;
    endtask

    // Reference encoder, straight from the coding rules in plain integer arithmetic.
    task automatic model_accept(input int dc, input int ch, input bit first);
        int diff, d, k, v, q, a;
        bit hyb;
        word_t w;
        if (ch >= NUM_CH) begin
            m_err = 1'b1;
            return;
        end
        hyb  = 1'b0;
        k    = 0;
        diff = dc - m_prev_dc[ch];
        if (first) begin
            d = dc;
            k = 5;
        end else begin
            d = (m_prev_diff[ch] < 0) ? -diff : diff;
            a = (m_prev_diff[ch] < 0) ? -m_prev_diff[ch] : m_prev_diff[ch];
            if (a >= 3)      k = 3;
            else if (a == 2) hyb = 1'b1;
            else             k = a;
        end
        v = (d >= 0) ? 2*d : -2*d - 1;
        if (!hyb) begin
            q      = flog2(v + (1 << k)) - k;
            w.code = v + (1 << k);
            w.len  = 2*q + k + 1;
        end else if (v < 8) begin
            w.code = 4 | (v & 3);
            w.len  = (v >> 2) + 3;
        end else begin
            q      = flog2((v - 8) + 8) - 3;
            w.code = (v - 8) + 8;
            w.len  = 2*q + 7;
        end
        w.ch  = ch;
        w.first = first;
        exp_q.push_back(w);
        m_prev_dc[ch]   = dc;
        m_prev_diff[ch] = first ? 3 : diff;
    endtask

    // Single compare process: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            model_reset();
        end else begin
            word_t w, g;
            check("err_ch", err_ch, m_err);
`ifdef DC_BITCNT_EN
            for (int c = 0; c < NUM_CH; c++)
                check("bitcnt", out_bitcnt[32*c +: 32], m_bc[c]);
`endif
            if (held) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_code", out_code, h_code);
                check("hold_len", out_len, h_len);
                check("hold_ch", out_ch, h_ch);
            end
            check("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_event("unexpected_output_word");
                end else begin
                    w = exp_q.pop_front();
                    check("out_code", out_code, w.code);
                    check("out_len", out_len, w.len);
                    check("out_ch", out_ch, w.ch);
                    g.code  = int'(out_code);
                    g.len   = int'(out_len);
                    g.ch    = int'(out_ch);
                    g.first = w.first;
                    got_q.push_back(g);
                    if (w.first) m_bc[w.ch] = w.len;
                    else if (m_bc[w.ch] + w.len > 64'hFFFF_FFFF) m_bc[w.ch] = 64'hFFFF_FFFF;
                    else m_bc[w.ch] = m_bc[w.ch] + w.len;
                end
            end
            held   = out_valid && !out_ready;
            h_code = out_code;
            h_len  = out_len;
            h_ch   = out_ch;
            if (in_valid && in_ready) begin
                n_acc++;
                model_accept(int'($signed(in_dc)), int'(in_ch), in_first);
            end
        end
    end

    // Tasks are entered and left one time unit after a rising edge.
    task automatic apply_reset();
        @(posedge clk); #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_code", out_code, '0);
        check("rst_out_len", out_len, '0);
        check("rst_out_ch", out_ch, '0);
        check("rst_err_ch", err_ch, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic send(input int dc, input int ch, input bit first);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_dc    = COEFF_W'(dc);
        in_ch    = CH_W'(ch);
        in_first = first;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_event("send_timeout");
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_event("drain_timeout");
        @(posedge clk); #1;
    endtask

    task automatic check_got(input int idx, input int code, input int len, input int ch);
        if (idx >= got_q.size()) begin
            fail_event("literal_word_missing");
        end else begin
            check("lit_code", got_q[idx].code, code);
            check("lit_len", got_q[idx].len, len);
            check("lit_ch", got_q[idx].ch, ch);
        end
    endtask

    localparam int SEQ_N = 8;
    int seq_dc [SEQ_N] = '{100, -40, -45, 300, 7, 7, -32768, 32767};
    int seq_ch [SEQ_N] = '{0, 1, 1, 2, 0, 0, 2, 2};
    bit seq_fs [SEQ_N] = '{0, 1, 0, 0, 0, 1, 0, 0};

    initial begin
        int lat, n0;
        model_reset();
        apply_reset();
        out_ready = 1'b1;

        // Single-channel run from a restarted predictor.
        got_q.delete();
        send(0, 0, 1); send(0, 0, 0); send(1, 0, 0); send(3, 0, 0); send(4, 0, 0);
        drain();
        check("t1_count", got_q.size(), 5);
        check_got(0, 'h20, 6, 0); check_got(1, 'h8, 4, 0); check_got(2, 'h3, 3, 0);
        check_got(3, 'h6, 4, 0);  check_got(4, 'h6, 3, 0);

        // Negative previous diff flips the sign of the next residual.
        got_q.delete();
        send(10, 0, 1); send(8, 0, 0); send(7, 0, 0);
        drain();
        check("t2_count", got_q.size(), 3);
        check_got(0, 'h34, 6, 0); check_got(1, 'hB, 4, 0); check_got(2, 'h6, 3, 0);
`ifdef DC_BITCNT_EN
        check("t2_bitcnt_ch0", out_bitcnt[31:0], 13);
`endif

        // Hybrid escape path: prev_diff=2 then delta 5.
        got_q.delete();
        send(0, 1, 1); send(2, 1, 0); send(7, 1, 0);
        drain();
        check("t3_count", got_q.size(), 3);
        check_got(0, 'h20, 6, 1); check_got(1, 'hC, 4, 1); check_got(2, 'hA, 7, 1);

        // Interleaved channels keep independent contexts.
        got_q.delete();
        send(0, 0, 1); send(0, 0, 0); send(5, 1, 1); send(1, 0, 0);
        send(7, 1, 0); send(3, 0, 0); send(4, 0, 0);
        drain();
        check("t4_count", got_q.size(), 7);
        check_got(0, 'h20, 6, 0); check_got(1, 'h8, 4, 0); check_got(2, 'h2A, 6, 1);
        check_got(3, 'h3, 3, 0);  check_got(4, 'hC, 4, 1); check_got(5, 'h6, 4, 0);
        check_got(6, 'h6, 3, 0);

        // Latency from accept to out_valid with the output side ready.
        in_valid = 1'b1; in_dc = COEFF_W'(9); in_ch = CH_W'(2); in_first = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = t;
                break;
            end
        end
        check("latency", lat, 3);
        @(posedge clk); #1;
        drain();

        // Output stall: three words fill the pipe, then input is held off.
        got_q.delete();
        out_ready = 1'b0;
        n0 = n_acc;
        in_valid = 1'b1; in_dc = COEFF_W'(5); in_ch = CH_W'(2); in_first = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_accepted", n_acc - n0, 3);
        @(posedge clk); #1;
        drain();
        check("stall_out_count", got_q.size(), 3);

        // Out-of-range channel: no word, sticky error.
        got_q.delete();
        send(7, 3, 0);
        drain();
        check("bad_ch_err", err_ch, 1'b1);
        check("bad_ch_no_word", got_q.size(), 0);

        // Reset mid-stream then replay must reproduce a clean run.
        apply_reset();
        out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < SEQ_N; i++) send(seq_dc[i], seq_ch[i], seq_fs[i]);
        drain();
        ref_q = got_q;
        for (int i = 0; i < 4; i++) send(seq_dc[i] + 3, seq_ch[i], seq_fs[i]);
        apply_reset();
        out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < SEQ_N; i++) send(seq_dc[i], seq_ch[i], seq_fs[i]);
        drain();
        check("replay_count", got_q.size(), ref_q.size());
        for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
            check("replay_code", got_q[i].code, ref_q[i].code);
            check("replay_len", got_q[i].len, ref_q[i].len);
        end

        // Randomized traffic with random backpressure and one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) apply_reset();
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 8);
            in_ch     = ($urandom_range(0, 15) == 0) ? CH_W'(3) : CH_W'($urandom_range(0, NUM_CH-1));
            in_first  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1)
                in_dc = COEFF_W'(int'($urandom_range(0, 40)) - 20);
            else
                in_dc = COEFF_W'($urandom_range(0, 65535));
            out_ready = ($urandom_range(0, 9) < 7);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
